// File: rtl/xgmii_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// xgmii_tx_framer_pkg
// Shared XGMII definitions for the TX framer:
//   - control characters (IDLE, START, TERM, ERROR)
//   - fixed 64-bit words: idle, preamble/start, terminate-in-lane-0, error
//   - framer state encodings
// -----------------------------------------------------------------------------
package xgmii_tx_framer_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERROR = 8'hFE;

  localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
  // Start character in lane 0, six preamble bytes, SFD in lane 7.
  localparam logic [63:0] PREAMBLE_WORD = {8'hD5, {6{8'h55}}, XGMII_START};
  localparam logic [63:0] TERM_WORD     = {{7{XGMII_IDLE}}, XGMII_TERM};
  localparam logic [63:0] ERROR_WORD    = {8{XGMII_ERROR}};

  localparam logic [7:0] TXC_ALL_CTRL = 8'hFF;
  localparam logic [7:0] TXC_ALL_DATA = 8'h00;
  localparam logic [7:0] TXC_START    = 8'h01;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PRE   = 3'd1,
    ST_DATA  = 3'd2,
    ST_TERM  = 3'd3,
    ST_ERR   = 3'd4,
    ST_DRAIN = 3'd5,
    ST_IFG   = 3'd6
  } state_t;

endpackage

// File: rtl/xgmii_tx_framer_term.sv
// -----------------------------------------------------------------------------
// xgmii_tx_term
// Combinational builder for the last word of a frame. Lanes below n carry
// data, lane n carries the terminate character, lanes above carry idles.
// txc is set for every lane at or above n. With n=8 the word is pure data.
// Ports:
//   i_data   [63:0]  last frame word, lane 0 = [7:0]
//   i_cnt_m1 [2:0]   valid byte count minus 1 (n-1)
//   o_txd    [63:0]  XGMII data for this word
//   o_txc    [7:0]   XGMII control flags for this word
// -----------------------------------------------------------------------------
module xgmii_tx_term
  import xgmii_tx_framer_pkg::*;
(
  input  logic [63:0] i_data,
  input  logic [2:0]  i_cnt_m1,
  output logic [63:0] o_txd,
  output logic [7:0]  o_txc
);

  logic [3:0] w_n;
  assign w_n = {1'b0, i_cnt_m1} + 4'd1;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign o_txd[gi*8 +: 8] = (4'(gi) <  w_n) ? i_data[gi*8 +: 8] :
                                (4'(gi) == w_n) ? XGMII_TERM : XGMII_IDLE;
      assign o_txc[gi]        = (4'(gi) >= w_n);
    end
  endgenerate

endmodule

// File: rtl/xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// xgmii_tx_framer
// Pulls pre-built frames (DA..FCS) from a first-word-fall-through FIFO and
// emits them on a 64-bit XGMII TX interface with start/preamble, terminate,
// underrun error signalling and a minimum inter-frame gap.
// Ports:
//   sys_clk, sys_rst_n      clock, async active-low reset
//   fifo_dout [71:0]        FIFO head: [63:0] data, [71] eof, [66:64] n-1
//   fifo_empty              head word invalid
//   fifo_rd_en              pop head this cycle (combinational)
//   tx_enable               link-up qualifier, sampled only between frames
//   xgmii_txd/xgmii_txc     registered XGMII outputs
//   busy                    state is not IDLE
//   tx_frames               good frames terminated (wraps)
//   tx_underruns            underrun-aborted frames (saturates)
// -----------------------------------------------------------------------------
module xgmii_tx_framer
  import xgmii_tx_framer_pkg::*;
#(
  parameter int unsigned IFG_WORDS = 2
)(
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [71:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic        tx_enable,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic        busy,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_underruns
);

  localparam logic [3:0] IFG_LOAD = 4'(IFG_WORDS - 1);

  state_t      r_state;
  logic [63:0] r_txd;
  logic [7:0]  r_txc;
  logic [3:0]  r_ifg_cnt;
  logic [31:0] r_frames;
  logic [15:0] r_underruns;

  state_t      w_state_next;
  logic [63:0] w_txd_next;
  logic [7:0]  w_txc_next;
  logic        w_pop;
  logic        w_frame_done;
  logic        w_underrun;

  logic        w_eof;
  logic        w_start;
  logic [63:0] w_last_txd;
  logic [7:0]  w_last_txc;
  logic        w_unused;

  assign w_eof    = fifo_dout[71];
  assign w_start  = tx_enable && !fifo_empty;
  // Reserved head bits [70:67] are deliberately ignored.
  assign w_unused = &{1'b0, fifo_dout[70:67]};

  xgmii_tx_term u_term (
    .i_data   (fifo_dout[63:0]),
    .i_cnt_m1 (fifo_dout[66:64]),
    .o_txd    (w_last_txd),
    .o_txc    (w_last_txc)
  );

  always_comb begin
    w_state_next = r_state;
    w_txd_next   = IDLE_WORD;
    w_txc_next   = TXC_ALL_CTRL;
    w_pop        = 1'b0;
    w_frame_done = 1'b0;
    w_underrun   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_next = ST_PRE;
      end
      ST_PRE: begin
        w_txd_next   = PREAMBLE_WORD;
        w_txc_next   = TXC_START;
        w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (fifo_empty) begin
          w_txd_next   = ERROR_WORD;
          w_underrun   = 1'b1;
          w_state_next = ST_ERR;
        end else begin
          w_pop = 1'b1;
          if (!w_eof) begin
            w_txd_next = fifo_dout[63:0];
            w_txc_next = TXC_ALL_DATA;
          end else begin
            w_txd_next = w_last_txd;
            w_txc_next = w_last_txc;
            if (fifo_dout[66:64] == 3'd7) begin
              // Full last word: terminate goes out on its own next cycle.
              w_state_next = ST_TERM;
            end else begin
              w_frame_done = 1'b1;
              w_state_next = ST_IFG;
            end
          end
        end
      end
      ST_TERM: begin
        w_txd_next   = TERM_WORD;
        w_frame_done = 1'b1;
        w_state_next = ST_IFG;
      end
      ST_ERR: begin
        w_txd_next   = TERM_WORD;
        w_state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!fifo_empty) begin
          w_pop = 1'b1;
          if (w_eof) w_state_next = ST_IFG;
        end
      end
      ST_IFG: begin
        // The last gap cycle also makes the IDLE start decision, so the next
        // start word follows exactly IFG_WORDS idles after the terminate.
        if (r_ifg_cnt == 4'd0) w_state_next = w_start ? ST_PRE : ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= ST_IDLE;
      r_txd       <= IDLE_WORD;
      r_txc       <= TXC_ALL_CTRL;
      r_ifg_cnt   <= IFG_LOAD;
      r_frames    <= 32'd0;
      r_underruns <= 16'd0;
    end else begin
      r_state   <= w_state_next;
      r_txd     <= w_txd_next;
      r_txc     <= w_txc_next;
      r_ifg_cnt <= (r_state == ST_IFG) ? r_ifg_cnt - 4'd1 : IFG_LOAD;
      if (w_frame_done) r_frames <= r_frames + 32'd1;
      if (w_underrun && (r_underruns != 16'hFFFF)) r_underruns <= r_underruns + 16'd1;
    end
  end

  assign fifo_rd_en   = w_pop;
  assign busy         = (r_state != ST_IDLE);
  assign xgmii_txd    = r_txd;
  assign xgmii_txc    = r_txc;
  assign tx_frames    = r_frames;
  assign tx_underruns = r_underruns;

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_xgmii_tx_framer
// Directed bench for xgmii_tx_framer with IFG_WORDS=2 and a queue-based
// first-word-fall-through FIFO model. Expected words are hand-computed.
// -----------------------------------------------------------------------------
module tb_xgmii_tx_framer;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;

  logic        sys_clk;
  logic        sys_rst_n;
  logic [71:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic        tx_enable;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic        busy;
  logic [31:0] tx_frames;
  logic [15:0] tx_underruns;

  int n_cmp = 0;
  int n_mis = 0;

  logic [71:0] q[$];
  bit          pop_req;

  xgmii_tx_framer #(.IFG_WORDS(2)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .fifo_dout    (fifo_dout),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .tx_enable    (tx_enable),
    .xgmii_txd    (xgmii_txd),
    .xgmii_txc    (xgmii_txc),
    .busy         (busy),
    .tx_frames    (tx_frames),
    .tx_underruns (tx_underruns)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // FWFT FIFO model: head is q[0]; a pop seen at the edge retires it shortly after.
  assign fifo_empty = (q.size() == 0);
  assign fifo_dout  = fifo_empty ? 72'd0 : q[0];

  always @(posedge sys_clk) begin
    pop_req = fifo_rd_en;
    #1;
    if (pop_req && q.size() != 0) void'(q.pop_front());
  end

  function automatic logic [71:0] mkw(input logic eof, input logic [2:0] cm1,
                                      input logic [3:0] rsv, input logic [63:0] d);
    return {eof, rsv, cm1, d};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [63:0] txd_e, input logic [7:0] txc_e);
    @(negedge sys_clk);
    check({tag, "_txd"}, xgmii_txd, txd_e);
    check({tag, "_txc"}, {56'd0, xgmii_txc}, {56'd0, txc_e});
    $display("t=%0t %s txd=%h txc=%h", $time, tag, xgmii_txd, xgmii_txc);
  endtask

  initial begin
    sys_rst_n = 1'b0;
    tx_enable = 1'b0;

    // ---- reset state ----
    repeat (2) @(negedge sys_clk);
    check("rst_txd", xgmii_txd, IDLE_W);
    check("rst_txc", {56'd0, xgmii_txc}, 64'hFF);
    check("rst_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_frames", {32'd0, tx_frames}, 64'd0);
    check("rst_underruns", {48'd0, tx_underruns}, 64'd0);
    sys_rst_n = 1'b1;
    tx_enable = 1'b1;
    @(negedge sys_clk);

    // ---- frame A: 3 words, last n=4, reserved bits set ----
    q.push_back(mkw(1'b0, 3'd0, 4'hF, 64'h0807060504030201));
    q.push_back(mkw(1'b0, 3'd5, 4'h0, 64'h100F0E0D0C0B0A09));
    q.push_back(mkw(1'b1, 3'd3, 4'hA, 64'hAABBCCDD44332211));
    chk_word("A_idle",  IDLE_W, 8'hFF);
    chk_word("A_pre",   PRE_W,  8'h01);
    chk_word("A_d0",    64'h0807060504030201, 8'h00);
    chk_word("A_d1",    64'h100F0E0D0C0B0A09, 8'h00);
    chk_word("A_last",  64'h070707FD44332211, 8'hF0);
    check("A_frames", {32'd0, tx_frames}, 64'd1);
    check("A_busy_ifg", {63'd0, busy}, 64'd1);
    chk_word("A_ifg0",  IDLE_W, 8'hFF);
    chk_word("A_ifg1",  IDLE_W, 8'hFF);
    check("A_busy_idle", {63'd0, busy}, 64'd0);

    // ---- frame B: 2 words, last n=8 -> separate terminate word ----
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'h2233445566778899));
    q.push_back(mkw(1'b1, 3'd7, 4'h0, 64'h0123456789ABCDEF));
    chk_word("B_idle",  IDLE_W, 8'hFF);
    chk_word("B_pre",   PRE_W,  8'h01);
    chk_word("B_d0",    64'h2233445566778899, 8'h00);
    chk_word("B_d1",    64'h0123456789ABCDEF, 8'h00);
    check("B_frames_pre_term", {32'd0, tx_frames}, 64'd1);
    chk_word("B_term",  TERM_W, 8'hFF);
    check("B_frames", {32'd0, tx_frames}, 64'd2);
    chk_word("B_ifg0",  IDLE_W, 8'hFF);
    chk_word("B_ifg1",  IDLE_W, 8'hFF);

    // ---- frames C and D back-to-back: exactly 2 idles between ----
    q.push_back(mkw(1'b1, 3'd0, 4'h0, 64'hFFFFFFFFFFFFFF5A));
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'hDEADBEEFCAFEF00D));
    q.push_back(mkw(1'b1, 3'd1, 4'h5, 64'h99999999999937C4));
    chk_word("C_idle",  IDLE_W, 8'hFF);
    chk_word("C_pre",   PRE_W,  8'h01);
    chk_word("C_last",  64'h070707070707FD5A, 8'hFE);
    chk_word("CD_ifg0", IDLE_W, 8'hFF);
    chk_word("CD_ifg1", IDLE_W, 8'hFF);
    chk_word("D_pre",   PRE_W,  8'h01);
    chk_word("D_d0",    64'hDEADBEEFCAFEF00D, 8'h00);
    chk_word("D_last",  64'h0707070707FD37C4, 8'hFC);
    check("D_frames", {32'd0, tx_frames}, 64'd4);
    chk_word("D_ifg0",  IDLE_W, 8'hFF);
    chk_word("D_ifg1",  IDLE_W, 8'hFF);

    // ---- frame E: underrun after 1 of 4 words, rest drained ----
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'h1122334455667788));
    chk_word("E_idle",  IDLE_W, 8'hFF);
    chk_word("E_pre",   PRE_W,  8'h01);
    chk_word("E_d0",    64'h1122334455667788, 8'h00);
    chk_word("E_err",   ERR_W,  8'hFF);
    check("E_underruns", {48'd0, tx_underruns}, 64'd1);
    chk_word("E_term",  TERM_W, 8'hFF);
    check("E_drain_wait_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'hA1A1A1A1A1A1A1A1));
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'hB2B2B2B2B2B2B2B2));
    q.push_back(mkw(1'b1, 3'd5, 4'h0, 64'hC3C3C3C3C3C3C3C3));
    #1;
    check("E_drain_rd_en0", {63'd0, fifo_rd_en}, 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check($sformatf("E_drain_txd%0d", i), xgmii_txd, IDLE_W);
      check($sformatf("E_drain_rd_en%0d", i + 1), {63'd0, fifo_rd_en}, (i < 2) ? 64'd1 : 64'd0);
      $display("t=%0t E_drain%0d txd=%h rd_en=%b", $time, i, xgmii_txd, fifo_rd_en);
    end
    check("E_fifo_drained", 64'(q.size()), 64'd0);
    chk_word("E_ifg0",  IDLE_W, 8'hFF);
    chk_word("E_ifg1",  IDLE_W, 8'hFF);
    check("E_busy_idle", {63'd0, busy}, 64'd0);
    check("E_frames", {32'd0, tx_frames}, 64'd4);
    check("E_underruns_end", {48'd0, tx_underruns}, 64'd1);

    // ---- tx_enable low with a queued frame: idles only, no pops ----
    tx_enable = 1'b0;
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'h5555AAAA5555AAAA));
    q.push_back(mkw(1'b0, 3'd0, 4'h0, 64'h6666BBBB6666BBBB));
    q.push_back(mkw(1'b1, 3'd7, 4'h0, 64'h7777CCCC7777CCCC));
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      check($sformatf("F_dis_rd_en%0d", i), {63'd0, fifo_rd_en}, 64'd0);
      check($sformatf("F_dis_txd%0d", i), xgmii_txd, IDLE_W);
      $display("t=%0t F_dis%0d txd=%h rd_en=%b", $time, i, xgmii_txd, fifo_rd_en);
    end
    check("F_dis_fifo", 64'(q.size()), 64'd3);
    check("F_dis_busy", {63'd0, busy}, 64'd0);

    // ---- enable, then reset in the middle of the frame ----
    tx_enable = 1'b1;
    chk_word("F_idle",  IDLE_W, 8'hFF);
    chk_word("F_pre",   PRE_W,  8'h01);
    chk_word("F_d0",    64'h5555AAAA5555AAAA, 8'h00);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("R_txd", xgmii_txd, IDLE_W);
    check("R_txc", {56'd0, xgmii_txc}, 64'hFF);
    check("R_frames", {32'd0, tx_frames}, 64'd0);
    check("R_underruns", {48'd0, tx_underruns}, 64'd0);
    check("R_busy", {63'd0, busy}, 64'd0);
    check("R_rd_en", {63'd0, fifo_rd_en}, 64'd0);
    chk_word("R_next", IDLE_W, 8'hFF);
    check("R_fifo_kept", 64'(q.size()), 64'd2);
    tx_enable = 1'b0;
    sys_rst_n = 1'b1;
    chk_word("R_after0", IDLE_W, 8'hFF);
    chk_word("R_after1", IDLE_W, 8'hFF);
    check("R_fifo_kept_end", 64'(q.size()), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
